// File: rtl/pe_pipe_rr.sv
// Pipelined priority encoder: fixed lowest-index-first or round-robin search,
// with a registered result stage (S1) and a registered output stage (S2).
module pe_pipe_rr #(
  parameter int W  = 16,
  parameter int LW = 4,
  parameter int RR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [W-1:0]  in_oht,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [LW-1:0] out_bin,
  output logic [W-1:0]  out_oht,
  output logic          out_hit
);

  logic [LW-1:0] ptr;
  logic [LW-1:0] base;
  logic [LW-1:0] enc_bin;
  logic          enc_hit;
  logic          s1_vld;
  logic          s1_hit;
  logic [LW-1:0] s1_bin;
  logic [W-1:0]  s1_oht;
  logic          s2_adv;
  logic          s1_adv;
  logic          acc;

  // Handshake: S2 drains on out_rdy, S1 moves whenever S2 makes room.
  assign s2_adv = !out_vld || out_rdy;
  assign s1_adv = s1_vld && s2_adv;
  assign in_rdy = !rst && (!s1_vld || s1_adv);
  assign acc    = in_vld && in_rdy;

  // Fixed priority is simply a round-robin search that always starts at 0.
  assign base = (RR != 0) ? ptr : '0;

  // First set bit at or above base; index arithmetic wraps modulo W.
  always_comb begin
    logic [LW-1:0] idx;
    enc_hit = 1'b0;
    enc_bin = '0;
    idx     = '0;
    for (int i = 0; i < W; i++) begin
      idx = base + LW'(i);
      if (!enc_hit && in_oht[idx]) begin
        enc_hit = 1'b1;
        enc_bin = idx;
      end
    end
  end

  always_comb begin
    s1_oht = '0;
    if (s1_hit) s1_oht[s1_bin] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if ((RR != 0) && acc && enc_hit) begin
      ptr <= enc_bin + LW'(1);
    end
  end

  // A new acceptance refills S1 on the same edge it empties, so no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_bin <= '0;
    end else if (acc) begin
      s1_vld <= 1'b1;
      s1_hit <= enc_hit;
      s1_bin <= enc_bin;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_hit <= 1'b0;
      out_bin <= '0;
      out_oht <= '0;
    end else if (s2_adv) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_hit <= s1_hit;
        out_bin <= s1_bin;
        out_oht <= s1_oht;
      end
    end
  end

endmodule

// File: tb/tb_pe_pipe_rr.sv
// Bench for pe_pipe_rr: directed W=16 vectors on fixed and round-robin copies,
// then a randomized W=64 run against a scoreboard.
module tb_pe_pipe_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_in_vld;
  logic        a_out_rdy;
  logic [15:0] a_in_oht;
  logic        a_in_rdy  [2];
  logic        a_out_vld [2];
  logic        a_out_hit [2];
  logic [3:0]  a_out_bin [2];
  logic [15:0] a_out_oht [2];

  logic        b_in_vld;
  logic        b_out_rdy;
  logic [63:0] b_in_oht;
  logic        b_in_rdy  [2];
  logic        b_out_vld [2];
  logic        b_out_hit [2];
  logic [5:0]  b_out_bin [2];
  logic [63:0] b_out_oht [2];

  pe_pipe_rr #(.W(16), .LW(4), .RR(0)) a0 (
    .clk(clk), .rst(rst), .in_vld(a_in_vld), .in_rdy(a_in_rdy[0]), .in_oht(a_in_oht),
    .out_vld(a_out_vld[0]), .out_rdy(a_out_rdy), .out_bin(a_out_bin[0]),
    .out_oht(a_out_oht[0]), .out_hit(a_out_hit[0]));

  pe_pipe_rr #(.W(16), .LW(4), .RR(1)) a1 (
    .clk(clk), .rst(rst), .in_vld(a_in_vld), .in_rdy(a_in_rdy[1]), .in_oht(a_in_oht),
    .out_vld(a_out_vld[1]), .out_rdy(a_out_rdy), .out_bin(a_out_bin[1]),
    .out_oht(a_out_oht[1]), .out_hit(a_out_hit[1]));

  pe_pipe_rr #(.W(64), .LW(6), .RR(0)) b0 (
    .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy[0]), .in_oht(b_in_oht),
    .out_vld(b_out_vld[0]), .out_rdy(b_out_rdy), .out_bin(b_out_bin[0]),
    .out_oht(b_out_oht[0]), .out_hit(b_out_hit[0]));

  pe_pipe_rr #(.W(64), .LW(6), .RR(1)) b1 (
    .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy[1]), .in_oht(b_in_oht),
    .out_vld(b_out_vld[1]), .out_rdy(b_out_rdy), .out_bin(b_out_bin[1]),
    .out_oht(b_out_oht[1]), .out_hit(b_out_hit[1]));

  typedef struct packed {
    logic [15:0] oht;
    logic [3:0]  bin0;
    logic        hit0;
    logic [3:0]  bin1;
    logic        hit1;
  } vec_t;

  vec_t vecs [9];

  int eb   [2][8];
  bit eh   [2][8];
  int wp   [2];
  int rp   [2];
  int mptr [2];
  bit          hold [2];
  logic [5:0]  lb   [2];
  logic [63:0] lo   [2];
  logic        lh   [2];

  function automatic logic [63:0] onehot(input int bin, input bit hit);
    logic [63:0] r;
    r = '0;
    if (hit) r[bin] = 1'b1;
    return r;
  endfunction

  // Reference search: scan from the pointer to the top, then from 0 up to the pointer.
  function automatic void model(input logic [63:0] v, input int w, input int p,
                                output int bin, output bit hit);
    hit = 1'b0;
    bin = 0;
    for (int j = p; j < w; j++) if (!hit && v[j]) begin hit = 1'b1; bin = j; end
    for (int j = 0; j < p; j++) if (!hit && v[j]) begin hit = 1'b1; bin = j; end
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input int d, input int bin, input bit hit);
    check_output($sformatf("%s.vld%0d", tag, d), 64'(a_out_vld[d]), 64'd1);
    check_output($sformatf("%s.bin%0d", tag, d), 64'(a_out_bin[d]), 64'(bin));
    check_output($sformatf("%s.hit%0d", tag, d), 64'(a_out_hit[d]), 64'(hit));
    check_output($sformatf("%s.oht%0d", tag, d), 64'(a_out_oht[d]), onehot(bin, hit));
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++)
      check_output($sformatf("%s.vld%0d", tag, d), 64'(a_out_vld[d]), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in_vld = 1'b0; a_in_oht = '0; a_out_rdy = 1'b1;
    b_in_vld = 1'b0; b_in_oht = '0; b_out_rdy = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("rst.rdy%0d", d), 64'(a_in_rdy[d]), 64'd0);
      check_output($sformatf("rst.vld%0d", d), 64'(a_out_vld[d]), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check_output($sformatf("rel.rdy%0d", d), 64'(a_in_rdy[d]), 64'd1);
  endtask

  // One isolated input; its result must appear exactly two cycles later, once.
  task automatic apply_stimulus(input vec_t v, input string tag);
    a_in_vld = 1'b1; a_in_oht = v.oht; a_out_rdy = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check_output($sformatf("%s.rdy%0d", tag, d), 64'(a_in_rdy[d]), 64'd1);
    check_idle({tag, ".c0"});
    @(negedge clk);
    a_in_vld = 1'b0; a_in_oht = 16'hFFFF;
    #1;
    check_idle({tag, ".c1"});
    @(negedge clk);
    #1;
    check_a(tag, 0, int'(v.bin0), v.hit0);
    check_a(tag, 1, int'(v.bin1), v.hit1);
    @(negedge clk);
  endtask

  task automatic rand_step(input int d);
    int  bin;
    bit  hit;
    if (hold[d]) begin
      check_output($sformatf("rnd.hold.vld%0d", d), 64'(b_out_vld[d]), 64'd1);
      check_output($sformatf("rnd.hold.bin%0d", d), 64'(b_out_bin[d]), 64'(lb[d]));
      check_output($sformatf("rnd.hold.oht%0d", d), b_out_oht[d], lo[d]);
      check_output($sformatf("rnd.hold.hit%0d", d), 64'(b_out_hit[d]), 64'(lh[d]));
    end
    if (b_out_vld[d] && b_out_rdy) begin
      check_output($sformatf("rnd.pending%0d", d), 64'(wp[d] > rp[d]), 64'd1);
      if (wp[d] > rp[d]) begin
        bin = eb[d][rp[d] % 8];
        hit = eh[d][rp[d] % 8];
        rp[d]++;
        check_output($sformatf("rnd.bin%0d", d), 64'(b_out_bin[d]), 64'(bin));
        check_output($sformatf("rnd.hit%0d", d), 64'(b_out_hit[d]), 64'(hit));
        check_output($sformatf("rnd.oht%0d", d), b_out_oht[d], onehot(bin, hit));
      end
    end
    hold[d] = b_out_vld[d] && !b_out_rdy;
    lb[d] = b_out_bin[d]; lo[d] = b_out_oht[d]; lh[d] = b_out_hit[d];
    if (b_in_vld && b_in_rdy[d]) begin
      model(b_in_oht, 64, mptr[d], bin, hit);
      eb[d][wp[d] % 8] = bin;
      eh[d][wp[d] % 8] = hit;
      wp[d]++;
      if (d == 1 && hit) mptr[d] = (bin + 1) % 64;
    end
  endtask

  initial begin
    int b2b [3];
    vecs[0] = '{16'h0A00, 4'd9,  1'b1, 4'd9,  1'b1};
    vecs[1] = '{16'h0000, 4'd0,  1'b0, 4'd0,  1'b0};
    vecs[2] = '{16'h0401, 4'd0,  1'b1, 4'd10, 1'b1};
    vecs[3] = '{16'h0401, 4'd0,  1'b1, 4'd0,  1'b1};
    vecs[4] = '{16'h8000, 4'd15, 1'b1, 4'd15, 1'b1};
    vecs[5] = '{16'h0006, 4'd1,  1'b1, 4'd1,  1'b1};
    vecs[6] = '{16'h0006, 4'd1,  1'b1, 4'd2,  1'b1};
    vecs[7] = '{16'hFFFF, 4'd0,  1'b1, 4'd3,  1'b1};
    vecs[8] = '{16'h0010, 4'd4,  1'b1, 4'd4,  1'b1};
    b2b[0] = 0; b2b[1] = 8; b2b[2] = 15;

    do_reset();
    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Round-robin pointer now sits at 5; fill both stages with all-zero requests, then reset.
    a_out_rdy = 1'b0; a_in_vld = 1'b1; a_in_oht = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("full.vld%0d", d), 64'(a_out_vld[d]), 64'd1);
      check_output($sformatf("full.rdy%0d", d), 64'(a_in_rdy[d]), 64'd0);
    end
    rst = 1'b1;
    #1;
    check_idle("midrst");
    for (int d = 0; d < 2; d++)
      check_output($sformatf("midrst.rdy%0d", d), 64'(a_in_rdy[d]), 64'd0);
    @(negedge clk);
    rst = 1'b0; a_in_vld = 1'b0; a_out_rdy = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check_output($sformatf("midrel.rdy%0d", d), 64'(a_in_rdy[d]), 64'd1);
    apply_stimulus('{16'h00A4, 4'd2, 1'b1, 4'd2, 1'b1}, "fresh");

    do_reset();
    for (int k = 0; k < 6; k++) begin
      a_in_vld = (k < 3);
      a_in_oht = (k < 3) ? 16'h8101 : 16'h0000;
      #1;
      if (k < 3)
        for (int d = 0; d < 2; d++)
          check_output($sformatf("b2b%0d.rdy%0d", k, d), 64'(a_in_rdy[d]), 64'd1);
      if (k >= 2 && k < 5) begin
        check_a($sformatf("b2b%0d", k), 0, 0, 1'b1);
        check_a($sformatf("b2b%0d", k), 1, b2b[k-2], 1'b1);
      end else begin
        check_idle($sformatf("b2b%0d", k));
      end
      @(negedge clk);
    end
    apply_stimulus('{16'h8101, 4'd0, 1'b1, 4'd0, 1'b1}, "wrap");

    // Five cycles of back-pressure with a continuous request stream.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      a_out_rdy = (k >= 5);
      a_in_vld  = (k < 6);
      a_in_oht  = (k == 0) ? 16'h0030 : (k == 1) ? 16'h0300 : 16'h4000;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (k < 6)
          check_output($sformatf("bp%0d.rdy%0d", k, d), 64'(a_in_rdy[d]),
                       ((k < 2) || (k == 5)) ? 64'd1 : 64'd0);
        if (k < 2 || k == 8) check_output($sformatf("bp%0d.vld%0d", k, d), 64'(a_out_vld[d]), 64'd0);
        else if (k < 6)      check_a($sformatf("bp%0d", k), d, 4, 1'b1);
        else if (k == 6)     check_a($sformatf("bp%0d", k), d, 8, 1'b1);
        else                 check_a($sformatf("bp%0d", k), d, 14, 1'b1);
      end
      @(negedge clk);
    end

    do_reset();
    for (int d = 0; d < 2; d++) begin
      wp[d] = 0; rp[d] = 0; mptr[d] = 0; hold[d] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      b_in_vld  = ($urandom_range(0, 3) != 0);
      b_out_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       b_in_oht = '0;
        1:       b_in_oht = 64'h1 << $urandom_range(0, 63);
        default: b_in_oht = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      #1;
      for (int d = 0; d < 2; d++) rand_step(d);
      @(negedge clk);
    end
    b_in_vld = 1'b0; b_out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int d = 0; d < 2; d++) rand_step(d);
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("rnd.leftover%0d", d), 64'(wp[d] - rp[d]), 64'd0);
      check_output($sformatf("rnd.count%0d", d), 64'(wp[d] > 1000), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
